// File: rtl/lspc_timer.sv
//==============================================================================
// Module   : lspc_timer
// Brief    : LSPC pixel-rate 32-bit down-counter with reload modes and an
//            underflow interrupt pulse. Optional build macro
//            LSPC_TIMER_STOP_EN adds a stop flag that stalls ticks in the
//            PAL border.
// Revision : 1.0
//==============================================================================
`default_nettype none

module lspc_timer (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        CLK_EN,
    input  logic        WR_MODE,
    input  logic        WR_TIMER_HIGH,
    input  logic        WR_TIMER_LOW,
`ifdef LSPC_TIMER_STOP_EN
    input  logic        WR_TIMER_STOP,
    input  logic        PAL_BORDER,
`endif
    input  logic [15:0] DATA,
    input  logic        VBL_START,
    output logic        TIMER_IRQ,
    output logic        TIMER_IRQ_EN,
    output logic [31:0] TIMER_CNT
);

    localparam logic [31:0] c_cnt_wrap = 32'hFFFF_FFFF;
    localparam logic [31:0] c_cnt_one  = 32'd1;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [3:0]  r_mode;
    logic [31:0] r_reload;
    logic [31:0] r_cnt;
    logic [31:0] w_cnt_nxt;
    logic        r_irq;
    logic        w_irq_nxt;

    logic        w_wr_reload;
    logic        w_vbl_reload;
    logic        w_stall;
    logic        w_tick;
    logic [31:0] w_wr_value;

    // A write-triggered reload must see the half being written this cycle.
    assign w_wr_value = {(WR_TIMER_HIGH ? DATA : r_reload[31:16]),
                         (WR_TIMER_LOW  ? DATA : r_reload[15:0])};

    assign w_wr_reload  = WR_TIMER_LOW & r_mode[1];
    assign w_vbl_reload = VBL_START & r_mode[2];

`ifdef LSPC_TIMER_STOP_EN
    logic r_stop;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_stop <= 1'b0;
        end else if (WR_TIMER_STOP) begin
            r_stop <= DATA[0];
        end
    end

    assign w_stall = r_stop & PAL_BORDER;
`else
    assign w_stall = 1'b0;
`endif

    assign w_tick = CLK_EN & ~w_stall & (r_state == ST_RUN);

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_mode   <= 4'h0;
            r_reload <= 32'h0;
        end else begin
            if (WR_MODE) begin
                r_mode <= DATA[7:4];
            end
            if (WR_TIMER_HIGH) begin
                r_reload[31:16] <= DATA;
            end
            if (WR_TIMER_LOW) begin
                r_reload[15:0] <= DATA;
            end
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state <= ST_IDLE;
            r_cnt   <= 32'h0;
            r_irq   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_irq   <= w_irq_nxt;
        end
    end

    // Write reload beats VBL reload beats the tick; a superseded tick is lost.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_irq_nxt   = 1'b0;
        if (w_wr_reload) begin
            w_cnt_nxt   = w_wr_value;
            w_state_nxt = ST_RUN;
        end else if (w_vbl_reload) begin
            w_cnt_nxt   = r_reload;
            w_state_nxt = ST_RUN;
        end else if (w_tick) begin
            if (r_cnt == 32'h0) begin
                w_irq_nxt = 1'b1;
                w_cnt_nxt = r_mode[3] ? r_reload : c_cnt_wrap;
            end else begin
                w_cnt_nxt = r_cnt - c_cnt_one;
            end
        end
    end

    assign TIMER_IRQ    = r_irq;
    assign TIMER_IRQ_EN = r_mode[0];
    assign TIMER_CNT    = r_cnt;

endmodule

`default_nettype wire

// File: tb/tb_lspc_timer.sv
//==============================================================================
// Module   : tb_lspc_timer
// Brief    : Directed self-checking bench for lspc_timer.
// Revision : 1.0
//==============================================================================
`default_nettype none

module tb_lspc_timer;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        CLK_EN;
    logic        WR_MODE;
    logic        WR_TIMER_HIGH;
    logic        WR_TIMER_LOW;
    logic [15:0] DATA;
    logic        VBL_START;
    logic        TIMER_IRQ;
    logic        TIMER_IRQ_EN;
    logic [31:0] TIMER_CNT;
`ifdef LSPC_TIMER_STOP_EN
    logic        WR_TIMER_STOP;
    logic        PAL_BORDER;
`endif

    int n_checks = 0;
    int n_errors = 0;

    lspc_timer u_dut (
        .CLK           (CLK),
        .RESET         (RESET),
        .CLK_EN        (CLK_EN),
        .WR_MODE       (WR_MODE),
        .WR_TIMER_HIGH (WR_TIMER_HIGH),
        .WR_TIMER_LOW  (WR_TIMER_LOW),
`ifdef LSPC_TIMER_STOP_EN
        .WR_TIMER_STOP (WR_TIMER_STOP),
        .PAL_BORDER    (PAL_BORDER),
`endif
        .DATA          (DATA),
        .VBL_START     (VBL_START),
        .TIMER_IRQ     (TIMER_IRQ),
        .TIMER_IRQ_EN  (TIMER_IRQ_EN),
        .TIMER_CNT     (TIMER_CNT)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 ns after the rising edge.
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic wr(input logic m, input logic hi, input logic lo, input logic [15:0] d);
        WR_MODE = m; WR_TIMER_HIGH = hi; WR_TIMER_LOW = lo; DATA = d;
        step();
        WR_MODE = 1'b0; WR_TIMER_HIGH = 1'b0; WR_TIMER_LOW = 1'b0; DATA = 16'h0;
    endtask

    task automatic ticks(input int n, output int irqs);
        irqs = 0;
        for (int i = 0; i < n; i++) begin
            CLK_EN = 1'b1;
            step();
            if (TIMER_IRQ === 1'b1) irqs++;
        end
        CLK_EN = 1'b0;
    endtask

    task automatic do_reset();
        RESET = 1'b1;
        step();
        RESET = 1'b0;
    endtask

    initial begin
        int       irqs;
        logic [8:0] pat;

        RESET = 1'b1; CLK_EN = 1'b0; WR_MODE = 1'b0; WR_TIMER_HIGH = 1'b0;
        WR_TIMER_LOW = 1'b0; DATA = 16'h0; VBL_START = 1'b0;
`ifdef LSPC_TIMER_STOP_EN
        WR_TIMER_STOP = 1'b0; PAL_BORDER = 1'b0;
`endif
        #2;
        chk("rst_irq", {31'h0, TIMER_IRQ}, 32'h0);
        chk("rst_irq_en", {31'h0, TIMER_IRQ_EN}, 32'h0);
        chk("rst_cnt", TIMER_CNT, 32'h0);
        step(); step();
        RESET = 1'b0;

        // Single-shot reload path
        wr(1'b1, 1'b0, 1'b0, 16'h0020);
        wr(1'b0, 1'b1, 1'b0, 16'h0000);
        wr(1'b0, 1'b0, 1'b1, 16'h0003);
        chk("oneshot_load", TIMER_CNT, 32'h3);
        ticks(3, irqs);
        chk("oneshot_pre_irqs", irqs, 0);
        chk("oneshot_at_zero", TIMER_CNT, 32'h0);
        ticks(1, irqs);
        chk("oneshot_irq", {31'h0, TIMER_IRQ}, 32'h1);
        chk("oneshot_wrap", TIMER_CNT, 32'hFFFF_FFFF);
        ticks(1, irqs);
        chk("oneshot_irq_width", {31'h0, TIMER_IRQ}, 32'h0);
        chk("oneshot_dec_wrap", TIMER_CNT, 32'hFFFF_FFFE);
        chk("irq_en_off", {31'h0, TIMER_IRQ_EN}, 32'h0);

        // Repeat mode, RELOAD=2 -> IRQ every 3 ticks
        wr(1'b1, 1'b0, 1'b0, 16'h00A0);
        wr(1'b0, 1'b0, 1'b1, 16'h0002);
        for (int i = 0; i < 9; i++) begin
            CLK_EN = 1'b1;
            step();
            pat[i] = TIMER_IRQ;
        end
        CLK_EN = 1'b0;
        chk("repeat_pattern", {23'h0, pat}, 32'h0000_0124);
        chk("repeat_reloaded", TIMER_CNT, 32'h2);

        // Write reload coincident with a tick at zero
        wr(1'b1, 1'b0, 1'b0, 16'h0020);
        wr(1'b0, 1'b0, 1'b1, 16'h0001);
        ticks(1, irqs);
        chk("wvt_zero", TIMER_CNT, 32'h0);
        WR_TIMER_LOW = 1'b1; DATA = 16'h0005; CLK_EN = 1'b1;
        step();
        WR_TIMER_LOW = 1'b0; DATA = 16'h0; CLK_EN = 1'b0;
        chk("wvt_no_irq", {31'h0, TIMER_IRQ}, 32'h0);
        chk("wvt_cnt", TIMER_CNT, 32'h5);

        // MODE write takes effect only from the following cycle
        do_reset();
        chk("rst2_cnt", TIMER_CNT, 32'h0);
        wr(1'b1, 1'b0, 1'b1, 16'h0029);
        chk("mode_delay_no_reload", TIMER_CNT, 32'h0);
        wr(1'b0, 1'b0, 1'b1, 16'h0029);
        chk("mode_delay_reload", TIMER_CNT, 32'h29);

        // VBL reload from IDLE
        do_reset();
        wr(1'b1, 1'b0, 1'b0, 16'h0040);
        wr(1'b0, 1'b0, 1'b1, 16'h0010);
        chk("vbl_no_wr_reload", TIMER_CNT, 32'h0);
        ticks(5, irqs);
        chk("idle_no_irq", irqs, 0);
        chk("idle_hold", TIMER_CNT, 32'h0);
        VBL_START = 1'b1;
        step();
        VBL_START = 1'b0;
        chk("vbl_load", TIMER_CNT, 32'h10);
        ticks(16, irqs);
        chk("vbl_pre_irqs", irqs, 0);
        ticks(1, irqs);
        chk("vbl_irq", {31'h0, TIMER_IRQ}, 32'h1);
        chk("vbl_wrap", TIMER_CNT, 32'hFFFF_FFFF);

        // Priority: write > VBL > tick
        wr(1'b1, 1'b0, 1'b0, 16'h0060);
        WR_TIMER_LOW = 1'b1; VBL_START = 1'b1; CLK_EN = 1'b1; DATA = 16'h0007;
        step();
        WR_TIMER_LOW = 1'b0; VBL_START = 1'b0; CLK_EN = 1'b0; DATA = 16'h0;
        chk("prio_wr_over_vbl", TIMER_CNT, 32'h7);
        ticks(2, irqs);
        VBL_START = 1'b1; CLK_EN = 1'b1;
        step();
        VBL_START = 1'b0; CLK_EN = 1'b0;
        chk("prio_vbl_over_tick", TIMER_CNT, 32'h7);

        // Asynchronous reset mid-count
        wr(1'b0, 1'b0, 1'b1, 16'h0003);
        ticks(2, irqs);
        chk("pre_reset_cnt", TIMER_CNT, 32'h1);
        #3;
        RESET = 1'b1;
        #1;
        chk("async_rst_cnt", TIMER_CNT, 32'h0);
        chk("async_rst_irq", {31'h0, TIMER_IRQ}, 32'h0);
        step();
        RESET = 1'b0;
        ticks(100, irqs);
        chk("post_reset_irqs", irqs, 0);
        chk("post_reset_cnt", TIMER_CNT, 32'h0);

        // IRQ enable tracks MODE[0]
        wr(1'b1, 1'b0, 1'b0, 16'h0010);
        chk("irq_en_on", {31'h0, TIMER_IRQ_EN}, 32'h1);

`ifdef LSPC_TIMER_STOP_EN
        wr(1'b1, 1'b0, 1'b0, 16'h0020);
        wr(1'b0, 1'b0, 1'b1, 16'h0014);
        WR_TIMER_STOP = 1'b1; DATA = 16'h0001;
        step();
        WR_TIMER_STOP = 1'b0; DATA = 16'h0;
        PAL_BORDER = 1'b1;
        ticks(10, irqs);
        chk("stop_hold", TIMER_CNT, 32'h14);
        PAL_BORDER = 1'b0;
        ticks(3, irqs);
        chk("stop_resume", TIMER_CNT, 32'h11);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
